// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: a registered Moore FSM that sequences the shared
// memory / single-ALU datapath and drives every mux select and write enable.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       iord,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic [1:0] pcsrc,
  output logic [3:0] alucontrol,
  output logic [3:0] state,
  output logic       instr_done
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_IEXEC    = 4'd9;
  localparam logic [3:0] S_IWB      = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  logic [3:0] r_state;
  logic [3:0] w_nextState;
  logic [3:0] w_viewState;
  logic       w_functOk;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_instrDone;

  assign w_functOk = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                     (funct == FN_OR)  || (funct == FN_SLT);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = S_FETCH;
    case (r_state)
      S_FETCH:  w_nextState = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:             w_nextState = S_MEMADR;
          OP_RTYPE:                 w_nextState = w_functOk ? S_EXECUTE : S_FETCH;
          OP_BEQ:                   w_nextState = S_BRANCH;
          OP_ADDI, OP_ORI, OP_SLTI: w_nextState = S_IEXEC;
          OP_J:                     w_nextState = S_JUMP;
          default:                  w_nextState = S_FETCH;
        endcase
      end
      S_MEMADR:  w_nextState = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: w_nextState = S_MEMWB;
      S_EXECUTE: w_nextState = S_ALUWB;
      S_IEXEC:   w_nextState = S_IWB;
      default:   w_nextState = S_FETCH;
    endcase
  end

  // While reset is high the outputs show FETCH, whatever the register holds.
  assign w_viewState = reset ? S_FETCH : r_state;
  assign state       = w_viewState;

  always_comb begin
    w_pcwrite   = 1'b0;
    w_branch    = 1'b0;
    w_irwrite   = 1'b0;
    w_memwrite  = 1'b0;
    w_regwrite  = 1'b0;
    w_instrDone = 1'b0;
    iord        = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    zeroext     = 1'b0;
    pcsrc       = 2'b00;
    alucontrol  = ALU_ADD;
    case (w_viewState)
      S_FETCH: begin
        alusrcb   = 2'b01;
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_SLTI, OP_J: w_instrDone = 1'b0;
          OP_RTYPE: w_instrDone = ~w_functOk;
          default:  w_instrDone = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMREAD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg    = 1'b1;
        w_regwrite  = 1'b1;
        w_instrDone = 1'b1;
      end
      S_MEMWRITE: begin
        iord        = 1'b1;
        w_memwrite  = 1'b1;
        w_instrDone = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        case (funct)
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      S_ALUWB: begin
        regdst      = 1'b1;
        w_regwrite  = 1'b1;
        w_instrDone = 1'b1;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        alucontrol  = ALU_SUB;
        pcsrc       = 2'b01;
        w_branch    = 1'b1;
        w_instrDone = 1'b1;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        zeroext = (opcode == OP_ORI);
        case (opcode)
          OP_ORI:  alucontrol = ALU_OR;
          OP_SLTI: alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      S_IWB: begin
        zeroext     = (opcode == OP_ORI);
        w_regwrite  = 1'b1;
        w_instrDone = 1'b1;
      end
      S_JUMP: begin
        pcsrc       = 2'b10;
        w_pcwrite   = 1'b1;
        w_instrDone = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen       = ~reset & (w_pcwrite | (w_branch & zero));
  assign irwrite    = ~reset & w_irwrite;
  assign memwrite   = ~reset & w_memwrite;
  assign regwrite   = ~reset & w_regwrite;
  assign instr_done = ~reset & w_instrDone;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: a cycle-indexed
// per-instruction reference model feeds an expectation queue drained by a monitor.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb;
  logic       zeroext;
  logic [1:0] pcsrc;
  logic [3:0] alucontrol;
  logic [3:0] state;
  logic       instr_done;

  typedef struct packed {
    logic [3:0] state;
    logic       pcen;
    logic       irwrite;
    logic       iord;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [1:0] pcsrc;
    logic [3:0] alucontrol;
    logic       instrDone;
  } exp_t;

  typedef enum {K_LW, K_SW, K_R, K_BEQ, K_ADDI, K_ORI, K_SLTI, K_J, K_BAD} kind_t;

  exp_t expQ[$];
  int   vectorCount = 0;
  int   missCount   = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pcen(pcen), .irwrite(irwrite), .iord(iord), .memwrite(memwrite),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .zeroext(zeroext), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .state(state), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b001000: return K_ADDI;
      6'b001101: return K_ORI;
      6'b001010: return K_SLTI;
      6'b000010: return K_J;
      6'b000000: begin
        if (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
            fn == 6'b100101 || fn == 6'b101010) return K_R;
        return K_BAD;
      end
      default: return K_BAD;
    endcase
  endfunction

  function automatic int cpi(input kind_t k);
    case (k)
      K_LW:         return 5;
      K_BEQ, K_J:   return 3;
      K_BAD:        return 2;
      default:      return 4;
    endcase
  endfunction

  function automatic logic [3:0] rAlu(input logic [5:0] fn);
    case (fn)
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic exp_t resetExp();
    exp_t e = '0;
    e.alusrcb    = 2'b01;
    e.alucontrol = 4'b0010;
    return e;
  endfunction

  // Expected outputs in cycle k (0 = fetch) of one instruction.
  function automatic exp_t refModel(input logic [5:0] op, input logic [5:0] fn,
                                    input int k, input logic z);
    kind_t kd = classify(op, fn);
    exp_t  e  = '0;
    e.alucontrol = 4'b0010;
    if (k == 0) begin
      e.pcen = 1; e.irwrite = 1; e.alusrcb = 2'b01;
    end else if (k == 1) begin
      e.state = 4'd1; e.alusrcb = 2'b11; e.instrDone = (kd == K_BAD);
    end else begin
      case (kd)
        K_LW, K_SW: begin
          if (k == 2) begin
            e.state = 4'd2; e.alusrca = 1; e.alusrcb = 2'b10;
          end else if (kd == K_SW) begin
            e.state = 4'd5; e.iord = 1; e.memwrite = 1; e.instrDone = 1;
          end else if (k == 3) begin
            e.state = 4'd3; e.iord = 1;
          end else begin
            e.state = 4'd4; e.memtoreg = 1; e.regwrite = 1; e.instrDone = 1;
          end
        end
        K_R: begin
          if (k == 2) begin
            e.state = 4'd6; e.alusrca = 1; e.alucontrol = rAlu(fn);
          end else begin
            e.state = 4'd7; e.regdst = 1; e.regwrite = 1; e.instrDone = 1;
          end
        end
        K_BEQ: begin
          e.state = 4'd8; e.alusrca = 1; e.alucontrol = 4'b0110; e.pcsrc = 2'b01;
          e.pcen = z; e.instrDone = 1;
        end
        K_ADDI, K_ORI, K_SLTI: begin
          e.zeroext = (kd == K_ORI);
          if (k == 2) begin
            e.state = 4'd9; e.alusrca = 1; e.alusrcb = 2'b10;
            e.alucontrol = (kd == K_ORI) ? 4'b0001 : (kd == K_SLTI) ? 4'b0111 : 4'b0010;
          end else begin
            e.state = 4'd10; e.regwrite = 1; e.instrDone = 1;
          end
        end
        K_J: begin
          e.state = 4'd11; e.pcsrc = 2'b10; e.pcen = 1; e.instrDone = 1;
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  // zeroMode: 0/1 force zero, 2 random; resetAt: cycle to abort with reset, -1 none.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input int zeroMode, input int resetAt);
    int n = cpi(classify(op, fn));
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        opcode = op;
        funct  = fn;
      end
      zero = (zeroMode == 2) ? logic'($urandom_range(1, 0)) : logic'(zeroMode);
      if (k == resetAt) begin
        reset = 1'b1;
        expQ.push_back(resetExp());
        break;
      end
      reset = 1'b0;
      expQ.push_back(refModel(op, fn, k, zero));
    end
  endtask

  task automatic checkOutput(input exp_t want);
    exp_t got;
    got = '{state, pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg,
            alusrca, alusrcb, zeroext, pcsrc, alucontrol, instr_done};
    vectorCount++;
    if (got !== want) begin
      missCount++;
      $display("[TB] FAIL ctrl_vec t=%0t op=%b fn=%b got=%h want=%h",
               $time, opcode, funct, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    logic [5:0] legalOps [8];
    logic [5:0] rFuncts  [5];
    logic [5:0] op, fn;
    legalOps = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                 6'b001000, 6'b001101, 6'b001010, 6'b000010};
    rFuncts  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      expQ.push_back(resetExp());
    end

    for (int i = 0; i < 5; i++) applyStimulus(6'b000000, rFuncts[i], 2, -1);
    applyStimulus(6'b100011, 6'h15, 2, -1);
    applyStimulus(6'b101011, 6'h2a, 2, -1);
    applyStimulus(6'b000100, 6'h00, 1, -1);
    applyStimulus(6'b000100, 6'h00, 0, -1);
    applyStimulus(6'b001000, 6'h01, 2, -1);
    applyStimulus(6'b001101, 6'h02, 2, -1);
    applyStimulus(6'b001010, 6'h03, 2, -1);
    applyStimulus(6'b000010, 6'h04, 2, -1);
    applyStimulus(6'b111111, 6'b100000, 2, -1);
    applyStimulus(6'b000000, 6'b000000, 2, -1);
    applyStimulus(6'b100011, 6'h00, 2, 3);
    applyStimulus(6'b101011, 6'h00, 2, 2);

    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(7, 0) == 0) ? 6'($urandom) : legalOps[$urandom_range(7, 0)];
      fn = ($urandom_range(4, 0) == 0) ? 6'($urandom) : rFuncts[$urandom_range(4, 0)];
      applyStimulus(op, fn, 2, ($urandom_range(19, 0) == 0) ? int'($urandom_range(4, 0)) : -1);
    end

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      missCount++;
      $display("[TB] FAIL drain left=%0d want=0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle MIPS control unit. A registered Moore state machine sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback steps for add, sub, and, or, slt, lw, sw, beq, addi, ori, slti and j. It replaces the single-cycle combinational controller when the processor is built as the multicycle variant. It drives every datapath mux select and write enable, and computes the PC enable from the ALU zero flag.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- opcode  input  6  instr[31:26] from the instruction register
- funct  input  6  instr[5:0] from the instruction register
- zero  input  1  ALU zero flag, same cycle
- pcen  output  1  PC write enable = pcwrite | (branch & zero)
- irwrite  output  1  instruction register write enable
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  output  1  data memory write enable
- regwrite  output  1  register file write enable
- regdst  output  1  register write address select: 0 = rt, 1 = rd
- memtoreg  output  1  register write data select: 0 = ALUOut, 1 = MDR
- alusrca  output  1  ALU operand A select: 0 = PC, 1 = A register
- alusrcb  output  2  ALU operand B select: 00 = B, 01 = 4, 10 = extended immediate, 11 = extended immediate << 2
- zeroext  output  1  immediate extension: 1 = zero-extend (ori), 0 = sign-extend
- pcsrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  output  4  ALU operation: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111
- state  output  4  current state, for debug
- instr_done  output  1  high in the final cycle of each instruction

## Operation
State encodings and next-state rules:
- FETCH=0: next DECODE.
- DECODE=1: next state selected by opcode:
  - 100011 or 101011 → MEMADR
  - 000000 → EXECUTE, only when funct ∈ {100000, 100010, 100100, 100101, 101010}; any other funct → FETCH
  - 000100 → BRANCH
  - 001000, 001101 or 001010 → IEXEC
  - 000010 → JUMP
  - any other opcode → FETCH
- MEMADR=2: next MEMREAD if opcode = 100011, else MEMWRITE.
- MEMREAD=3 → MEMWB=4 → FETCH.
- MEMWRITE=5 → FETCH.
- EXECUTE=6 → ALUWB=7 → FETCH.
- BRANCH=8 → FETCH.
- IEXEC=9 → IWB=10 → FETCH.
- JUMP=11 → FETCH.
- Codes 12–15 are illegal and → FETCH.

Per-state outputs. Any signal not listed is 0, and alucontrol defaults to 0010.
- FETCH: iord=0, alusrca=0, alusrcb=01, pcsrc=00, irwrite=1, pcwrite=1.
- DECODE: alusrca=0, alusrcb=11 (branch target into ALUOut).
- MEMADR: alusrca=1, alusrcb=10.
- MEMREAD: iord=1.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, instr_done=1.
- MEMWRITE: iord=1, memwrite=1, instr_done=1.
- EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct: 100000→0010, 100010→0110, 100100→0000, 100101→0001, 101010→0111.
- ALUWB: regdst=1, memtoreg=0, regwrite=1, instr_done=1.
- BRANCH: alusrca=1, alusrcb=00, alucontrol=0110, pcsrc=01, branch=1, instr_done=1.
- IEXEC: alusrca=1, alusrcb=10, alucontrol from opcode: addi→0010, ori→0001, slti→0111. zeroext=1 for ori only.
- IWB: regdst=0, memtoreg=0, regwrite=1, instr_done=1. zeroext holds its IEXEC value.
- JUMP: pcsrc=10, pcwrite=1, instr_done=1.
- Instructions abandoned in DECODE (unsupported opcode or funct) assert instr_done=1 in DECODE and perform no writes.

## Timing
- The state register updates on the rising clk edge. All outputs are combinational from state, opcode and funct (Moore, plus the IR fields). pcen is additionally combinational from zero.
- Reset:
  - reset=1 at an edge loads state=FETCH, overriding any state, including mid-instruction.
  - While reset=1, pcen, irwrite, memwrite, regwrite and instr_done are forced to 0. All other outputs take their FETCH values.
  - The first fetch executes in the first cycle with reset=0.
- Cycles per instruction, counted from FETCH: lw 5, sw 4, R-type 4, addi/ori/slti 4, beq 3, j 3, unsupported 2.
- opcode and funct are stable from DECODE onward because irwrite is asserted only in FETCH. The FSM reads them in DECODE and MEMADR, and for the ALU decode in EXECUTE and IEXEC.
- beq: pcen = zero during BRANCH only. zero=0 leaves the PC at the value written in FETCH (PC+4).
- The write enables (irwrite, pcen, memwrite, regwrite) are each high for at most one cycle per instruction, except pcen, which is high in FETCH plus at most one later cycle (BRANCH or JUMP).

## Test plan
- Reset held for 2 cycles, then released → state=0 and all enables 0 while reset=1. Cycle 1 after release: irwrite=1, pcen=1, alusrcb=01.
- add (opcode 000000, funct 100000) → states 0,1,6,7,0. In EXECUTE alucontrol=0010. In ALUWB regwrite=1, regdst=1, instr_done=1. Repeat for sub/and/or/slt expecting alucontrol 0110/0000/0001/0111.
- lw (100011) → states 0,1,2,3,4, then MEMWB with memtoreg=1 and regwrite=1. sw (101011) → states 0,1,2,5, with memwrite=1 and iord=1 only in MEMWRITE.
- beq (000100):
  - zero=1 in BRANCH → pcen=1, pcsrc=01.
  - zero=0 → pcen=0.
  - Both cases return to FETCH after 3 cycles.
- ori (001101) → IEXEC alucontrol=0001, zeroext=1, then IWB regwrite=1 and regdst=0. slti (001010) → alucontrol=0111, zeroext=0. j (000010) → JUMP with pcsrc=10 and pcen=1.
- Opcode 111111, and R-type funct 000000 → DECODE, then FETCH. No write enable is asserted and instr_done=1 in DECODE. Reset asserted during MEMREAD of lw → next state FETCH, and regwrite is never asserted for that lw.
